// File: rtl/cross_bar_pkg.sv
// Shared cross bar types and sizes used by the per-slave arbiters and muxes.
package cross_bar_pkg;

  localparam int unsigned MASTER_N = 4;
  localparam int unsigned SLAVE_N  = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SEL_W    = $clog2(SLAVE_N);
  localparam int unsigned MIDX_W   = $clog2(MASTER_N);

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [MASTER_N-1:0] msgrant_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/cross_bar_arbiter_if.sv
// Request/grant bundle between the masters, one slave and that slave's arbiter.
interface cross_bar_arbiter_if;
  import cross_bar_pkg::*;

  logic [MASTER_N-1:0]      master_req;
  addr_t [MASTER_N-1:0]     master_addr;
  logic                     slave_ack;
  msgrant_t                 msgrant;
  logic                     grant_valid;
  logic [MIDX_W-1:0]        grant_idx;
  logic                     timeout_err;

  // Arbiter side: consumes requests/ack, produces grant state.
  modport slave (
    input  master_req,
    input  master_addr,
    input  slave_ack,
    output msgrant,
    output grant_valid,
    output grant_idx,
    output timeout_err
  );

  // Requester side: drives requests/ack, observes grant state.
  modport master (
    output master_req,
    output master_addr,
    output slave_ack,
    input  msgrant,
    input  grant_valid,
    input  grant_idx,
    input  timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational cyclic priority encoder: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             found_o
);

  logic [IdxW-1:0] cand;

  // Scan from the farthest offset down so the nearest request to ptr_i wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      cand = IdxW'((int'(ptr_i) + i) % int'(Width));
      if (req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter: holds a one-hot grant until ack, withdrawal or timeout.
module cross_bar_arbiter
  import cross_bar_pkg::*;
#(
  parameter int unsigned SLAVE_ID = 0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                areset_i,
  cross_bar_arbiter_if.slave  arb_io
);

  // TIMEOUT == 0 disables the timer; a 1-bit timer keeps the widths legal.
  localparam int unsigned       TimerW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  msgrant_t            msgrant_q, msgrant_d;
  logic                grant_valid_q, grant_valid_d;
  logic [MIDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic                timeout_err_q, timeout_err_d;
  logic [MIDX_W-1:0]   ptr_q, ptr_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic [MASTER_N-1:0] qreq;
  logic [MIDX_W-1:0]   pick_idx;
  logic                pick_found;
  logic                unused_addr_lo;
  logic                ack_rel, wd_rel, to_rel;

  // Keep only requests whose top address bits select this slave.
  always_comb begin
    qreq           = '0;
    unused_addr_lo = 1'b0;
    for (int i = 0; i < int'(MASTER_N); i++) begin
      qreq[i] = arb_io.master_req[i] &&
                (arb_io.master_addr[i][ADDR_W-1 -: SEL_W] == SEL_W'(SLAVE_ID));
      unused_addr_lo = unused_addr_lo ^ (^arb_io.master_addr[i][ADDR_W-SEL_W-1:0]);
    end
  end

  rr_pick #(
    .Width (MASTER_N),
    .IdxW  (MIDX_W)
  ) u_rr_pick (
    .req_i   (qreq),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Release causes in priority order: ack, then withdrawal, then timeout.
  always_comb begin
    ack_rel = arb_io.slave_ack;
    wd_rel  = !arb_io.master_req[grant_idx_q];
    to_rel  = (TIMEOUT != 0) && (timer_q == TimerLast);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    msgrant_d     = msgrant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    timeout_err_d = 1'b0;
    ptr_d         = ptr_q;
    timer_d       = timer_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = GRANT;
          msgrant_d     = msgrant_t'(1) << pick_idx;
          grant_valid_d = 1'b1;
          grant_idx_d   = pick_idx;
          timer_d       = '0;
        end
      end
      GRANT: begin
        if (ack_rel || wd_rel || to_rel) begin
          state_d       = IDLE;
          msgrant_d     = '0;
          grant_valid_d = 1'b0;
          timeout_err_d = !ack_rel && !wd_rel;
          ptr_d         = (grant_idx_q == MIDX_W'(MASTER_N - 1)) ? '0
                                                                  : grant_idx_q + MIDX_W'(1);
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous reset that drops any grant immediately.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q       <= IDLE;
      msgrant_q     <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      timeout_err_q <= 1'b0;
      ptr_q         <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      msgrant_q     <= msgrant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      timeout_err_q <= timeout_err_d;
      ptr_q         <= ptr_d;
      timer_q       <= timer_d;
    end
  end

  assign arb_io.msgrant     = msgrant_q;
  assign arb_io.grant_valid = grant_valid_q;
  assign arb_io.grant_idx   = grant_idx_q;
  assign arb_io.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Directed bench for cross_bar_arbiter: one instance on slave 1, one on slave 0 with TIMEOUT=8.
module tb_cross_bar_arbiter;

  logic clk;
  logic areset;
  int   tests;
  int   fails;

  cross_bar_arbiter_if a_if ();
  cross_bar_arbiter_if b_if ();

  cross_bar_arbiter #(
    .SLAVE_ID (1),
    .TIMEOUT  (16)
  ) u_dut_a (
    .clk_i    (clk),
    .areset_i (areset),
    .arb_io   (a_if)
  );

  cross_bar_arbiter #(
    .SLAVE_ID (0),
    .TIMEOUT  (8)
  ) u_dut_b (
    .clk_i    (clk),
    .areset_i (areset),
    .arb_io   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] idx,
                       input logic te);
    chk({tag, " msgrant"}, 32'(a_if.msgrant), 32'(g));
    chk({tag, " valid"}, 32'(a_if.grant_valid), 32'(|g));
    chk({tag, " idx"}, 32'(a_if.grant_idx), 32'(idx));
    chk({tag, " terr"}, 32'(a_if.timeout_err), 32'(te));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] g, input logic [1:0] idx,
                       input logic te);
    chk({tag, " msgrant"}, 32'(b_if.msgrant), 32'(g));
    chk({tag, " valid"}, 32'(b_if.grant_valid), 32'(|g));
    chk({tag, " idx"}, 32'(b_if.grant_idx), 32'(idx));
    chk({tag, " terr"}, 32'(b_if.timeout_err), 32'(te));
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    tests  = 0;
    fails  = 0;
    areset = 1'b1;
    a_if.master_req  = '0;
    a_if.master_addr = '0;
    a_if.slave_ack   = 1'b0;
    b_if.master_req  = '0;
    b_if.master_addr = '0;
    b_if.slave_ack   = 1'b0;

    #12;
    chk_a("reset_a", 4'b0000, 2'd0, 1'b0);
    chk_b("reset_b", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    areset = 1'b0;

    // Slave 1: master 2 alone, ack two cycles after grant; master 1 targets slave 0.
    a_if.master_addr[2] = 32'h4000_0010;
    a_if.master_req[2]  = 1'b1;
    a_if.master_addr[1] = 32'h0000_0040;
    a_if.master_req[1]  = 1'b1;
    step(); chk_a("t1_grant", 4'b0100, 2'd2, 1'b0);
    step(); chk_a("t1_hold", 4'b0100, 2'd2, 1'b0);
    a_if.slave_ack = 1'b1;
    step(); chk_a("t1_release", 4'b0000, 2'd2, 1'b0);
    a_if.slave_ack      = 1'b0;
    a_if.master_req[2]  = 1'b0;
    a_if.master_addr[0] = 32'h4000_0000;
    a_if.master_addr[3] = 32'h7fff_fffc;
    a_if.master_req[0]  = 1'b1;
    a_if.master_req[3]  = 1'b1;
    // Pointer now at 3, so master 3 beats master 0.
    step(); chk_a("t1_ptr3", 4'b1000, 2'd3, 1'b0);
    a_if.master_req = '0;
    step(); chk_a("t1_withdraw", 4'b0000, 2'd3, 1'b0);
    a_if.slave_ack = 1'b1;
    step(); chk_a("t1_ack_idle", 4'b0000, 2'd3, 1'b0);
    a_if.slave_ack = 1'b0;

    // Slave 0: all masters request, ack in first grant cycle.
    b_if.master_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(); chk_b("t2_grant", 4'(1 << order[k]), 2'(order[k]), 1'b0);
      b_if.slave_ack = 1'b1;
      step(); chk_b("t2_gap", 4'b0000, 2'(order[k]), 1'b0);
      b_if.slave_ack = 1'b0;
    end
    b_if.master_req = '0;

    // Master 3 withdraws in its second grant cycle; master 1 targets slave 2.
    b_if.master_addr[1] = 32'h8000_0000;
    b_if.master_req     = 4'b1010;
    step(); chk_b("t5_grant", 4'b1000, 2'd3, 1'b0);
    step(); chk_b("t5_hold", 4'b1000, 2'd3, 1'b0);
    b_if.master_req[3] = 1'b0;
    step(); chk_b("t5_release", 4'b0000, 2'd3, 1'b0);
    step(); chk_b("t5_foreign1", 4'b0000, 2'd3, 1'b0);
    step(); chk_b("t5_foreign2", 4'b0000, 2'd3, 1'b0);

    // Move the pointer to 2, then reset in the middle of master 2's grant.
    b_if.master_addr[1] = 32'h0000_0100;
    step(); chk_b("t6_m1", 4'b0010, 2'd1, 1'b0);
    b_if.slave_ack = 1'b1;
    step(); chk_b("t6_m1_rel", 4'b0000, 2'd1, 1'b0);
    b_if.slave_ack  = 1'b0;
    b_if.master_req = 4'b0100;
    step(); chk_b("t6_m2", 4'b0100, 2'd2, 1'b0);
    #2 areset = 1'b1;
    #1;
    chk_b("t6_async_reset", 4'b0000, 2'd0, 1'b0);
    b_if.master_req = 4'b1011;
    @(negedge clk);
    areset = 1'b0;
    step(); chk_b("t6_ptr0", 4'b0001, 2'd0, 1'b0);

    // Master 0 never acked: forced release after 8 grant cycles, master 1 next.
    for (int c = 1; c < 8; c++) begin
      step(); chk_b("t3_hold", 4'b0001, 2'd0, 1'b0);
    end
    step(); chk_b("t3_timeout", 4'b0000, 2'd0, 1'b1);
    step(); chk_b("t3_next", 4'b0010, 2'd1, 1'b0);

    // Ack lands on the same edge the timeout would fire: ack wins.
    for (int c = 1; c < 8; c++) begin
      step(); chk_b("t4_hold", 4'b0010, 2'd1, 1'b0);
    end
    b_if.slave_ack = 1'b1;
    step(); chk_b("t4_ack_last", 4'b0000, 2'd1, 1'b0);
    b_if.slave_ack  = 1'b0;
    b_if.master_req = '0;
    step(); chk_b("t4_idle", 4'b0000, 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
